// File: rtl/mem_responder.sv
// Byte-wide memory responder shared by the CPU and the wasm parser.
// Fixed-latency request/ready handshake; the ROM region is write-protected once mapped.
module mem_responder #(
  parameter int DEPTH    = 4096,
  parameter int ROM_SIZE = 1024,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [7:0]  data_in,
  input  logic        memory_read_en,
  input  logic        memory_write_en,
  input  logic        rom_mapped,
  output logic [7:0]  data_out,
  output logic        memory_ready,
  output logic        error
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [31:0] ROM_W    = 32'(ROM_SIZE);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, READY, RECOVER} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_t;

  logic [7:0]  mem [DEPTH];
  state_t      state;
  logic [3:0]  cnt;
  op_t         op_p0;
  logic [31:0] addr_p0;
  logic [7:0]  data_p0;

  logic req_rd, req_wr, accept, commit;

  // X/Z on an enable must not start an access.
  assign req_rd = (memory_read_en === 1'b1);
  assign req_wr = (memory_write_en === 1'b1);

  // RECOVER's exit edge behaves like IDLE so a held enable is re-accepted
  // LATENCY+2 edges after the previous accept.
  assign accept = ((state == IDLE) || (state == RECOVER)) && (req_rd || req_wr);
  assign commit = (state == BUSY) && (cnt == 4'd0);

  function automatic logic in_range(input logic [31:0] a);
    return a < DEPTH_W;
  endfunction

  function automatic logic wr_allowed(input logic [31:0] a, input logic rm);
    return in_range(a) && !(rm && (a < ROM_W));
  endfunction

  // Request capture stage: address, data and op held for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= addr;
      data_p0 <= data_in;
      if (req_rd && req_wr)
        op_p0 <= OP_ILL;
      else if (req_rd)
        op_p0 <= OP_RD;
      else
        op_p0 <= OP_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && (op_p0 == OP_WR) && wr_allowed(addr_p0, rom_mapped))
      mem[addr_p0[AW-1:0]] <= data_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      memory_ready <= 1'b0;
      data_out     <= 8'h00;
      error        <= 1'b0;
    end else begin
      case (state)
        IDLE, RECOVER: begin
          memory_ready <= 1'b0;
          if (accept) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state        <= READY;
            memory_ready <= 1'b1;
            case (op_p0)
              OP_RD: begin
                if (in_range(addr_p0)) begin
                  data_out <= mem[addr_p0[AW-1:0]];
                end else begin
                  data_out <= 8'h00;
                  error    <= 1'b1;
                end
              end
              OP_WR: begin
                if (!wr_allowed(addr_p0, rom_mapped))
                  error <= 1'b1;
              end
              default: begin
                data_out <= 8'h00;
                error    <= 1'b1;
              end
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        READY: begin
          memory_ready <= 1'b0;
          state        <= RECOVER;
        end
        default: begin
          memory_ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
